pipe_trace_buffer: RTL and testbench
====================================

// Module: pipe_trace_buffer
// PURPOSE
// Parametrised on-chip trace capture for the pipelined CPU. Samples NUM_CH probe channels of CH_W bits
// (instruction, ALU result, forwarded operands, register addresses, ...) into a DEPTH-entry circular buffer.
// Captures around a masked-compare trigger on one selectable channel, then freezes for ordered readout.
// Instantiated beside Pipline; replaces per-cycle console monitoring with hardware capture.
// PARAMETERS
// NUM_CH     9   number of probe channels
// CH_W       32  width of each channel, bits
// DEPTH      64  buffer entries; power of two, >=2
// POST_TRIG  16  samples stored after the trigger sample; 0 <= POST_TRIG < DEPTH
// PORTS
// clk        in   1                  clock; all logic on rising edge
// rst        in   1                  synchronous reset, active-high
// probe_i    in   NUM_CH*CH_W        flattened probes; channel k = probe_i[k*CH_W +: CH_W]
// sample_en  in   1                  capture qualifier; a sample is one cycle with sample_en=1
// arm        in   1                  start a new capture (single-cycle pulse)
// trig_sel   in   $clog2(NUM_CH)     channel compared for trigger
// trig_val   in   CH_W               trigger compare value
// trig_mask  in   CH_W               1 = bit participates in compare
// rd_req     in   1                  pop oldest entry (DONE only)
// rd_data    out  NUM_CH*CH_W        read entry, registered
// rd_valid   out  1                  rd_data valid, one-cycle pulse
// state_o    out  2                  0 IDLE, 1 PRE, 2 POST, 3 DONE
// triggered  out  1                  trigger seen in current capture
// count      out  $clog2(DEPTH)+1    PRE/POST: entries held; DONE: entries unread
// BEHAVIOUR
// - Reset: state IDLE, wr/rd ptrs 0, count 0, triggered 0, rd_valid 0, rd_data 0. Memory not cleared.
// - rst mid-capture or mid-readout: IDLE next cycle, all captured contents discarded.
// - Trigger hit = sample_en & (((ch[trig_sel] ^ trig_val) & trig_mask) == 0). trig_sel >= NUM_CH never hits.
// - IDLE: no writes; arm -> PRE, wr_ptr=0, count=0, triggered=0.
// - PRE: each sample writes mem[wr_ptr]; wr_ptr wraps mod DEPTH; count saturates at DEPTH (oldest overwritten).
//   A hit stores the trigger sample, sets triggered, and goes to POST with post_cnt=POST_TRIG.
//   POST_TRIG=0 goes straight to DONE.
// - POST: each sample writes and decrements post_cnt; the write that takes it to 0 moves to DONE.
//   Further hits are ignored. sample_en=0 stalls both the write and the decrement.
// - DONE: no writes. rd_ptr = oldest entry = (count==DEPTH) ? wr_ptr : 0.
//   rd_req with count>0: rd_data=mem[rd_ptr] and rd_valid=1 the next cycle (latency 1); rd_ptr++, count--.
//   rd_req with count==0: ignored, rd_valid stays 0. Reads return oldest -> newest.
// - arm in PRE/POST: ignored. arm in DONE: new capture (as from IDLE); unread data discarded.
// - arm and rd_req in the same DONE cycle: arm wins, no read.
// - rd_req outside DONE: ignored. rd_data holds its last value when rd_valid=0.
// CONFIGURATION
// TRACE_TIMESTAMP_EN defined:
// - 32-bit free-running cycle counter (reset 0, wraps) stored with every written entry.
// - Extra output port rd_ts (out, 32), registered and aligned with rd_data/rd_valid.
// TRACE_TIMESTAMP_EN undefined: no counter, no rd_ts port; behaviour otherwise identical.
// TESTING  (NUM_CH=2, CH_W=8, DEPTH=8, POST_TRIG=2 unless stated)
// 1 Reset: rst high 2 cycles -> state_o=0, count=0, triggered=0, rd_valid=0, rd_data=0.
// 2 Wrap: arm; ch0=1..20 with sample_en every cycle; trig_val=10, mask=FF, sel=0
//   -> DONE after sample 12; count=8; 8 reads return ch0=5..12 in order; count ends at 0.
// 3 Early trigger: trig_val=3, ch0=1..20 -> DONE after sample 5, count=5, reads return 1..5.
// 4 Mask/select: sel=1, trig_val=10, mask=F0; ch1=1A is the first hit -> triggered=1 on that sample;
//   sel=2 -> never triggers.
// 5 Gaps: after the trigger, sample_en low 3 cycles -> state stays POST, count unchanged;
//   DONE only after 2 more qualified samples.
// 6 Corners: rst during POST -> IDLE next cycle, count=0. DONE with count=0: rd_req -> no rd_valid.
//   DONE: arm+rd_req together -> PRE, no read.
//   With TRACE_TIMESTAMP_EN: in test 2, rd_ts increments by exactly 1 per entry.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture of NUM_CH probe channels around a masked-compare trigger, frozen for ordered readout.
// Optional build macro TRACE_TIMESTAMP_EN stores a free-running cycle stamp with each entry (rd_ts port).
module pipe_trace_buffer #(
  parameter int NUM_CH    = 9,
  parameter int CH_W      = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*CH_W-1:0]        probe_i,
  input  logic                          sample_en,
  input  logic                          arm,
  input  logic [$clog2(NUM_CH)-1:0]     trig_sel,
  input  logic [CH_W-1:0]               trig_val,
  input  logic [CH_W-1:0]               trig_mask,
  input  logic                          rd_req,
  output logic [NUM_CH*CH_W-1:0]        rd_data,
  output logic                          rd_valid,
  output logic [1:0]                    state_o,
  output logic                          triggered,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]                   rd_ts,
`endif
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int DW    = NUM_CH * CH_W;
  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic              trig_q, trig_d;
  logic [DW-1:0]     rd_data_q;
  logic              rd_valid_q;
  logic [DW-1:0]     mem [DEPTH];

  logic              wr_en, rd_en, sel_ok, hit;
  logic [CH_W-1:0]   sel_ch;
  logic [CW-1:0]     count_inc;

  // Out-of-range selects leave sel_ok low so they can never hit.
  always_comb begin
    sel_ch = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_sel == SEL_W'(k)) begin
        sel_ch = probe_i[k*CH_W +: CH_W];
        sel_ok = 1'b1;
      end
    end
  end

  assign hit       = sample_en & sel_ok & (((sel_ch ^ trig_val) & trig_mask) == '0);
  assign count_inc = (count_q == FULL) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_d     = trig_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_PRE;
          wr_ptr_d = '0;
          count_d  = '0;
          trig_d   = 1'b0;
        end
      end
      S_PRE: begin
        if (sample_en) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_inc;
          if (hit) begin
            trig_d     = 1'b1;
            post_cnt_d = POST_INIT;
            state_d    = (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          count_d    = count_inc;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == AW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) begin
          state_d  = S_PRE;
          wr_ptr_d = '0;
          count_d  = '0;
          trig_d   = 1'b0;
        end else if (rd_req && (count_q != '0)) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A full buffer has wrapped, so its oldest entry sits at the next write slot.
    if ((state_d == S_DONE) && (state_q != S_DONE))
      rd_ptr_d = (count_d == FULL) ? wr_ptr_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= probe_i;
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] rd_ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (rd_en) rd_ts_q <= ts_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign rd_ts = rd_ts_q;
`endif

  assign state_o   = state_q;
  assign triggered = trig_q;
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: queue model of the capture buffer plus a read scoreboard.
module tb_pipe_trace_buffer;
  localparam int NUM_CH = 2, CH_W = 8, DEPTH = 8, POST_TRIG = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] probe_i;
  logic        sample_en, arm, rd_req;
  logic [0:0]  trig_sel;
  logic [7:0]  trig_val, trig_mask;
  logic [15:0] rd_data;
  logic        rd_valid, triggered;
  logic [1:0]  state_o;
  logic [3:0]  count;

  logic [23:0] probe3;
  logic        en3, arm3;
  logic [1:0]  sel3;
  logic [23:0] rd_data3;
  logic        rd_valid3, trig3;
  logic [1:0]  state3;
  logic [3:0]  count3;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts, rd_ts3;
`endif

  pipe_trace_buffer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) u_dut (
    .clk(clk), .rst(rst), .probe_i(probe_i), .sample_en(sample_en), .arm(arm),
    .trig_sel(trig_sel), .trig_val(trig_val), .trig_mask(trig_mask), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .state_o(state_o), .triggered(triggered),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .count(count));

  // Three-channel instance so that an out-of-range select is representable.
  pipe_trace_buffer #(.NUM_CH(3), .CH_W(CH_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) u_dut3 (
    .clk(clk), .rst(rst), .probe_i(probe3), .sample_en(en3), .arm(arm3),
    .trig_sel(sel3), .trig_val(trig_val), .trig_mask(trig_mask), .rd_req(1'b0),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .state_o(state3), .triggered(trig3),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts3),
`endif
    .count(count3));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  string       cur_test = "init";

  int          m_state;
  int          m_post;
  logic        m_trig;
  logic [31:0] m_ts;
  logic [15:0] m_last_rd;
  logic [47:0] cap[$];
  logic [47:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; sample_en = 1'b0; arm = 1'b0; rd_req = 1'b0; en3 = 1'b0; arm3 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_post = 0; m_trig = 1'b0; m_ts = '0; m_last_rd = '0;
    cap.delete(); exp_q.delete();
    check_val("rst_state", state_o, 2'd0);
    check_val("rst_count", count, 4'd0);
    check_val("rst_trig", triggered, 1'b0);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("rst_rd_data", rd_data, 16'h0);
  endtask

  task automatic step(input logic [7:0] c0, input logic [7:0] c1,
                      input logic en, input logic a, input logic rd);
    logic        hit;
    logic [7:0]  ch;
    logic [47:0] e;
    probe_i = {c1, c0}; sample_en = en; arm = a; rd_req = rd;
    ch  = trig_sel[0] ? c1 : c0;
    hit = en && (((ch ^ trig_val) & trig_mask) == 8'h00);
    case (m_state)
      0: if (a) begin m_state = 1; cap.delete(); m_trig = 1'b0; end
      1, 2: if (en) begin
        cap.push_back({m_ts, c1, c0});
        if (cap.size() > DEPTH) void'(cap.pop_front());
        if (m_state == 1) begin
          if (hit) begin
            m_trig = 1'b1; m_post = POST_TRIG;
            m_state = (POST_TRIG == 0) ? 3 : 2;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      default: begin
        if (a) begin m_state = 1; cap.delete(); m_trig = 1'b0; end
        else if (rd && cap.size() > 0) exp_q.push_back(cap.pop_front());
      end
    endcase
    @(posedge clk); #1;
    m_ts++;
    check_val("state", state_o, m_state[1:0]);
    check_val("count", count, cap.size());
    check_val("triggered", triggered, m_trig);
    check_val("rd_valid", rd_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_last_rd = e[15:0];
      check_val("rd_data", rd_data, e[15:0]);
`ifdef TRACE_TIMESTAMP_EN
      check_val("rd_ts", rd_ts, e[47:16]);
`endif
    end else begin
      check_val("rd_hold", rd_data, m_last_rd);
    end
    sample_en = 1'b0; arm = 1'b0; rd_req = 1'b0;
  endtask

  task automatic step3(input logic [23:0] p, input logic en, input logic a);
    probe3 = p; en3 = en; arm3 = a;
    @(posedge clk); #1;
    m_ts++;
    en3 = 1'b0; arm3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; probe_i = '0; sample_en = 1'b0; arm = 1'b0; rd_req = 1'b0;
    trig_sel = 1'b0; trig_val = '0; trig_mask = '0;
    probe3 = '0; en3 = 1'b0; arm3 = 1'b0; sel3 = '0;

    cur_test = "reset";
    do_reset(2);

    cur_test = "wrap";
    trig_sel = 1'b0; trig_val = 8'd10; trig_mask = 8'hFF;
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(8'(i), 8'(i + 64), 1'b1, 1'b0, 1'b0);
      if (i == 11) check_val("post_at_11", state_o, 2'd2);
      if (i == 12) check_val("done_at_12", state_o, 2'd3);
    end
    check_val("full_count", count, 4'd8);
    for (int k = 0; k < 8; k++) begin
      step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      check_val("order", rd_data[7:0], 8'(5 + k));
    end
    check_val("drained", count, 4'd0);
    step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_val("empty_read", rd_valid, 1'b0);

    cur_test = "early";
    do_reset(1);
    trig_val = 8'd3;
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) step(8'(i), 8'(i ^ 8'h5A), 1'b1, 1'b0, 1'b0);
    check_val("early_count", count, 4'd5);
    for (int k = 0; k < 3; k++) begin
      step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      check_val("early_order", rd_data[7:0], 8'(1 + k));
    end
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    check_val("arm_wins_state", state_o, 2'd1);
    check_val("arm_wins_noread", rd_valid, 1'b0);

    cur_test = "mask_sel";
    do_reset(1);
    trig_sel = 1'b1; trig_val = 8'h10; trig_mask = 8'hF0;
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step(8'h10, 8'h05, 1'b1, 1'b0, 1'b0);
    step(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0);
    check_val("no_hit_yet", triggered, 1'b0);
    step(8'h10, 8'h1A, 1'b1, 1'b0, 1'b0);
    check_val("hit_1A", triggered, 1'b1);
    step(8'h00, 8'h33, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h44, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    cur_test = "sel_range";
    do_reset(1);
    trig_mask = 8'h00; sel3 = 2'd3;
    step3(24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step3(24'(i * 3), 1'b1, 1'b0);
    check_val("sel3_state", state3, 2'd1);
    check_val("sel3_trig", trig3, 1'b0);
    check_val("sel3_count", count3, 4'd8);
    check_val("sel3_rdv", rd_valid3, 1'b0);
    check_val("sel3_rdd", rd_data3, 24'h0);
`ifdef TRACE_TIMESTAMP_EN
    check_val("sel3_ts", rd_ts3, 32'h0);
`endif
    sel3 = 2'd2;
    step3(24'h123456, 1'b1, 1'b0);
    check_val("sel2_trig", trig3, 1'b1);
    check_val("sel2_state", state3, 2'd2);

    cur_test = "gaps";
    do_reset(1);
    trig_sel = 1'b0; trig_val = 8'd3; trig_mask = 8'hFF;
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) step(8'(i), 8'h00, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(8'hEE, 8'hEE, 1'b0, 1'b1, 1'b0);
      check_val("gap_state", state_o, 2'd2);
      check_val("gap_count", count, 4'd3);
    end
    step(8'd4, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("still_post", state_o, 2'd2);
    step(8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("gap_done", state_o, 2'd3);
    for (int k = 0; k < 5; k++) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    cur_test = "rst_post";
    do_reset(1);
    step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) step(8'(i), 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("in_post", state_o, 2'd2);
    do_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
